key_uart_tx_bridge: RTL
=======================

// Module: key_uart_tx_bridge
// PURPOSE
//   Buffers key codes (ASCII from the PS/2 scan-code path) in a FIFO and drains
//   them into the async_transmitter via its start/busy handshake, so key bursts
//   faster than the UART are not lost. Optionally expands CR into CR+LF.
//   Replaces the direct scan_code_ready -> TxD_start wiring in the console top.
// PARAMETERS
//   DATA_WIDTH   8      width of a key code / UART byte
//   DEPTH        16     FIFO entries; power of two, >= 2
//   BUSY_LATENCY 2      cycles from tx_start until tx_busy is valid (incl. top-level register)
//   CR_CODE      8'h0D  code that triggers LF insertion when crlf_en=1
//   LF_CODE      8'h0A  code inserted after CR_CODE
// PORTS
//   clk         in   1                     system clock
//   rst         in   1                     asynchronous reset, active-high
//   key_valid   in   1                     one-cycle strobe: key_data is a new code
//   key_data    in   DATA_WIDTH            key code to enqueue
//   crlf_en     in   1                     1 = send LF_CODE after every CR_CODE
//   clear       in   1                     synchronous FIFO flush
//   tx_busy     in   1                     transmitter busy (registered TxD_busy)
//   tx_start    out  1                     one-cycle start strobe to the transmitter
//   tx_data     out  DATA_WIDTH            byte to send; stable while tx_start=1
//   fifo_count  out  $clog2(DEPTH)+1       occupied entries, 0..DEPTH
//   overflow    out  1                     sticky: a push was dropped (cleared by rst/clear)
//   drop_count  out  8                     dropped pushes, saturates at 255
// BEHAVIOUR
//   Reset (async, immediate): tx_start=0, tx_data=0, fifo_count=0, overflow=0,
//     drop_count=0, FSM=IDLE, rd/wr pointers=0. Mid-byte reset abandons the byte.
//   FIFO: push on key_valid when fifo_count<DEPTH; full -> push dropped, overflow
//     set, drop_count++ (saturating), regardless of a same-cycle pop.
//     Pop happens in IDLE only; push+pop same cycle -> count unchanged.
//     Pointers are log2(DEPTH) bits and wrap naturally DEPTH-1 -> 0.
//   FSM states: IDLE, START, SETTLE, WAIT, LF.
//     IDLE:   count>0 and tx_busy=0 -> pop head into tx_data, -> START.
//     START:  tx_start=1 for exactly this cycle -> SETTLE (counter=BUSY_LATENCY).
//     SETTLE: tx_busy ignored; counter reaches 0 -> WAIT.
//     WAIT:   tx_busy=0 -> if crlf_en and tx_data==CR_CODE and LF not yet sent:
//             tx_data<=LF_CODE, -> START (LF flagged as sent); else -> IDLE.
//     LF state is the LF-pending flag folded into the START/WAIT path; crlf_en is
//       sampled at WAIT exit of the CR byte.
//   Latency: key_valid into empty FIFO, idle UART -> tx_start 2 cycles later
//     (push cycle, IDLE pop cycle, START). Back-to-back bytes spaced by UART frame
//     time + BUSY_LATENCY + 2 cycles minimum.
//   tx_data holds its value outside START; never changes while tx_start=1.
//   clear: empties FIFO, resets overflow/drop_count, cancels a pending LF; a byte
//     already started completes (FSM continues WAIT). clear beats key_valid in
//     the same cycle (push discarded, not counted as a drop).
//   tx_busy high in IDLE (external sender) -> no pop until low.
// TESTING
//   Push 0x41 into empty FIFO, tx_busy idle -> tx_start 2 cycles later, tx_data=0x41, count back to 0.
//   Push 20 codes 0x30..0x43 in 20 cycles, UART busy, DEPTH=16 -> count=16, overflow=1,
//     drop_count=4, later sent sequence 0x30..0x3F exactly, in order, no duplicates.
//   crlf_en=1, push 0x0D,0x61 -> transmitted 0x0D,0x0A,0x61; crlf_en=0 -> 0x0D,0x61.
//   Push at count=DEPTH-1 with simultaneous pop; then fill through pointer wrap
//     twice -> data order preserved, count never exceeds DEPTH.
//   Assert clear while 5 queued and a CR in flight with crlf_en=1 -> CR completes,
//     no LF, no further tx_start, count=0, overflow=0.
//   Assert rst during WAIT with 3 queued -> all outputs zero same cycle (async), no
//     tx_start after release until a new key_valid.

Source files
------------

// File: rtl/key_uart_tx_bridge.sv
// key_uart_tx_bridge
//   Queues key codes in a FIFO and feeds them one at a time to a UART
//   transmitter through its start/busy handshake, so that key bursts arriving
//   faster than the serial line are not lost. When crlf_en is set, an LF_CODE
//   byte is sent after every CR_CODE byte.
//
// Ports
//   clk, rst     clock, asynchronous active-high reset
//   key_valid    one-cycle strobe: key_data holds a new code
//   key_data     code to enqueue
//   crlf_en      1 = follow every CR_CODE with LF_CODE
//   clear        synchronous flush of the FIFO, overflow flag and drop counter
//   tx_busy      transmitter busy (already registered at the top level)
//   tx_start     one-cycle start strobe to the transmitter
//   tx_data      byte to send; held outside the start cycle
//   fifo_count   occupied entries, 0..DEPTH
//   overflow     sticky: a push was dropped because the FIFO was full
//   drop_count   dropped pushes, saturating at 255
module key_uart_tx_bridge #(
  parameter int                    DATA_WIDTH   = 8,
  parameter int                    DEPTH        = 16,
  parameter int                    BUSY_LATENCY = 2,
  parameter logic [DATA_WIDTH-1:0] CR_CODE      = 8'h0D,
  parameter logic [DATA_WIDTH-1:0] LF_CODE      = 8'h0A
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    key_valid,
  input  logic [DATA_WIDTH-1:0]   key_data,
  input  logic                    crlf_en,
  input  logic                    clear,
  input  logic                    tx_busy,
  output logic                    tx_start,
  output logic [DATA_WIDTH-1:0]   tx_data,
  output logic [$clog2(DEPTH):0]  fifo_count,
  output logic                    overflow,
  output logic [7:0]              drop_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int LAT_W = $clog2(BUSY_LATENCY + 2);

  // The LF byte reuses START/SETTLE/WAIT; lf_done records whether the
  // current CR has already had its LF (or had it cancelled by clear).
  typedef enum logic [1:0] {IDLE, START, SETTLE, WAIT} state_t;
  state_t state, state_nxt;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      rd_ptr, wr_ptr;
  logic [LAT_W-1:0]      settle_cnt;
  logic                  lf_done;
  logic                  full, push, pop, drop, wait_exit, lf_go;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // clear wins over a same-cycle key_valid and suppresses any pop
  assign full      = (fifo_count == CNT_W'(DEPTH));
  assign push      = key_valid && !clear && !full;
  assign drop      = key_valid && !clear && full;
  assign pop       = (state == IDLE) && (fifo_count != '0) && !tx_busy && !clear;
  assign wait_exit = (state == WAIT) && !tx_busy;
  assign lf_go     = crlf_en && (tx_data == CR_CODE) && !lf_done && !clear;

  // FIFO storage (data only, no reset)
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= key_data;
  end

  // FIFO pointers, occupancy and drop accounting
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
      drop_count <= 8'd0;
    end else if (clear) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
      drop_count <= 8'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      fifo_count <= fifo_count + CNT_W'(1);
      else if (pop && !push) fifo_count <= fifo_count - CNT_W'(1);
      if (drop) begin
        overflow   <= 1'b1;
        drop_count <= sat_inc(drop_count);
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pop) state_nxt = START;
      START:   state_nxt = SETTLE;
      // tx_busy is not trustworthy until BUSY_LATENCY cycles after the strobe
      SETTLE:  if (settle_cnt <= LAT_W'(1)) state_nxt = WAIT;
      WAIT:    if (!tx_busy) state_nxt = lf_go ? START : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    tx_start = (state == START);
  end

  // Output byte, settle counter and LF bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_data    <= '0;
      lf_done    <= 1'b0;
      settle_cnt <= '0;
    end else begin
      if (pop) begin
        tx_data <= mem[rd_ptr];
        lf_done <= 1'b0;
      end else if (wait_exit && lf_go) begin
        tx_data <= LF_CODE;
        lf_done <= 1'b1;
      end else if (clear) begin
        lf_done <= 1'b1;
      end
      if (state == START)       settle_cnt <= LAT_W'(BUSY_LATENCY);
      else if (state == SETTLE) settle_cnt <= settle_cnt - LAT_W'(1);
    end
  end

endmodule
